nios2_mult_result_collector: RTL and testbench
==============================================

// Module: nios2_mult_result_collector
// PURPOSE
// - Drives a 3-product 16x16 multiplier cell and reassembles its partial products into the integer multiply result.
// - Cell products: p1=a_lo*b_lo, p2=a_lo*b_hi, p3=a_hi*b_lo.
// - Sits between the execute stage (command side) and the cell; returns result via valid/ready. All arithmetic unsigned.
// PARAMETERS
// - CELL_LATENCY  1  register stages inside cell gated by mul_en; legal 1..4, else elaboration $error
// PORTS
// - clk             in   1   clock
// - reset           in   1   synchronous reset, active-high
// - cmd_valid       in   1   operands offered
// - cmd_ready       out  1   collector idle, accepts operands
// - cmd_src1        in   32  operand A
// - cmd_src2        in   32  operand B
// - cmd_hi          in   1   request high word (MULT_HI_WORD_EN only)
// - mul_src1        out  32  operand A to cell
// - mul_src2        out  32  operand B to cell
// - mul_en          out  1   cell clock enable
// - mul_p1/p2/p3    in   32  cell partial products
// - rsp_valid       out  1   result available
// - rsp_ready       in   1   consumer takes result
// - rsp_result      out  32  product word
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous and active-high (reset). Single clock domain.
// - Reset (sampled high at edge): state=IDLE; rsp_valid=0, rsp_result=0, mul_en=0, mul_src1/2=0, counter=0; cmd_ready=0 while reset high.
// - Reset mid-operation aborts the op: no response is ever issued for it.
// - cmd_ready = (state==IDLE) & ~reset. Accept = cmd_valid & cmd_ready at edge k; operands are registered.
// - FSM states and transitions:
//   - IDLE -> ISSUE on accept.
//   - ISSUE -> SUM after CELL_LATENCY cycles.
//   - SUM -> RESP, or -> ISSUE2 if hi requested.
//   - ISSUE2 -> SUM2 -> RESP.
//   - RESP -> IDLE on rsp_ready.
// - ISSUE (cycles k+1..k+CELL_LATENCY): mul_src1/2 = captured A/B held stable; mul_en=1; down-counter tracks cycles.
// - mul_en=0 in every other state, so the cell holds its products.
// - SUM (cycle k+L+1, L=CELL_LATENCY): mid = p2+p3 (33 bits).
//   - lo_acc[49:0] = {16'b0,p1} + (mid<<16), registered.
//   - rsp_result = lo_acc[31:0], registered.
// - RESP: rsp_valid=1 from cycle k+L+2. rsp_result is held stable until the rsp_ready handshake.
//   - Back-pressure of any length is legal; cmd_ready stays 0 throughout.
// - Handshake cycle: rsp_valid drops next cycle; cmd_ready rises next cycle.
//   - No same-cycle accept: minimum issue interval is L+3 cycles.
// - mul_p* inputs are sampled only in SUM/SUM2; changes at other times are ignored.
// - cmd_src and cmd_valid are ignored when cmd_ready=0. cmd_valid dropping before accept is legal.
// - Widths: the result is taken mod 2^32; overflow is never flagged. No sign correction (signed/unsigned low word identical).
// CONFIGURATION
// - Macro MULT_HI_WORD_EN.
// - Defined:
//   - cmd_hi port exists. With cmd_hi=1 at accept, SUM goes to ISSUE2.
//   - ISSUE2: mul_src1={16'b0,A[31:16]}, mul_src2={16'b0,B[31:16]}; mul_en=1 for L cycles.
//   - SUM2: rsp_result = (lo_acc[49:32] + p1)[31:0], i.e. bits[63:32] of unsigned A*B.
//   - rsp_valid at k+2L+3.
//   - cmd_hi=0 behaves exactly as the undefined build.
// - Undefined: no cmd_hi port; ISSUE2/SUM2 unreachable; low word only.
// TESTING
// - L=1, A=7, B=6 accepted cycle k -> mul_en high cycle k+1 only; rsp_valid cycle k+3; rsp_result=0x0000002A.
// - A=0xFFFFFFFF, B=0xFFFFFFFF -> rsp_result=0x00000001.
//   - With MULT_HI_WORD_EN and cmd_hi=1 -> rsp_result=0xFFFFFFFE at k+5 (L=1).
// - A=0x00010000, B=0x00010000 -> low=0x00000000.
//   - With MULT_HI_WORD_EN and cmd_hi=1 -> 0x00000001.
// - Back-pressure: A=0x1234, B=0x10 (result 0x00012340), rsp_ready=0 for 5 cycles.
//   - rsp_result stable and rsp_valid=1 throughout; cmd_ready=0 throughout.
//   - Accept resumes the cycle after rsp_ready=1.
// - Reset asserted during ISSUE (L=4) -> next cycle IDLE; mul_en=0; rsp_valid stays 0; no response for the aborted op.
//   - First cycle with reset low: cmd_ready=1.
// - Back-to-back: two commands with rsp_ready tied 1, L=2 -> accepts exactly 5 cycles apart; results in order, each correct.

Source files
------------

// File: rtl/nios2_mult_result_collector.sv
// nios2_mult_result_collector
//   Sequences a 3-product 16x16 multiplier cell (p1=a_lo*b_lo, p2=a_lo*b_hi,
//   p3=a_hi*b_lo) and reassembles the partial products into the 32-bit
//   low word of an unsigned multiply, returned over a valid/ready response.
//   Optional macro MULT_HI_WORD_EN adds cmd_hi, which runs a second cell
//   pass on the operand high halves and returns bits [63:32] instead.
// Parameters
//   CELL_LATENCY  register stages inside the cell gated by mul_en (1..4)
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/ready            operand handshake (cmd_src1/2, cmd_hi)
//   mul_src1/2, mul_en         operands and clock enable to the cell
//   mul_p1/p2/p3               partial products from the cell
//   rsp_valid/ready            result handshake (rsp_result)
module nios2_mult_result_collector #(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_src1,
  input  logic [31:0] cmd_src2,
`ifdef MULT_HI_WORD_EN
  input  logic        cmd_hi,
`endif
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] mul_p1,
  input  logic [31:0] mul_p2,
  input  logic [31:0] mul_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result
);

  if (CELL_LATENCY < 1 || CELL_LATENCY > 4) begin : g_bad_latency
    $error("CELL_LATENCY must be in 1..4");
  end

  localparam logic [1:0] CNT_INIT = 2'(CELL_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SUM,
    S_ISSUE2,
    S_SUM2,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic        hi_q, hi_d;
  logic [49:0] lo_acc_q, lo_acc_d;
  logic [31:0] result_q, result_d;
  logic [32:0] mid;
  logic        hi_in;

`ifdef MULT_HI_WORD_EN
  assign hi_in = cmd_hi;
`else
  assign hi_in = 1'b0;
`endif

  assign mid = {1'b0, mul_p2} + {1'b0, mul_p3};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    hi_d     = hi_q;
    lo_acc_d = lo_acc_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_ISSUE;
          src1_d  = cmd_src1;
          src2_d  = cmd_src2;
          hi_d    = hi_in;
          cnt_d   = CNT_INIT;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 2'd0) state_d = S_SUM;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_SUM: begin
        lo_acc_d = {18'b0, mul_p1} + ({17'b0, mid} << 16);
        result_d = lo_acc_d[31:0];
        if (hi_q) begin
          // The operand registers are reused for the second pass: the cell's
          // p1 then yields a_hi*b_hi, which is all SUM2 needs.
          state_d = S_ISSUE2;
          src1_d  = {16'b0, src1_q[31:16]};
          src2_d  = {16'b0, src2_q[31:16]};
          cnt_d   = CNT_INIT;
        end else begin
          state_d = S_RESP;
        end
      end
      S_ISSUE2: begin
        if (cnt_q == 2'd0) state_d = S_SUM2;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_SUM2: begin
        result_d = {14'b0, lo_acc_q[49:32]} + mul_p1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      hi_q     <= 1'b0;
      lo_acc_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      hi_q     <= hi_d;
      lo_acc_q <= lo_acc_d;
      result_q <= result_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE) && !reset;
  assign mul_en     = (state_q == S_ISSUE) || (state_q == S_ISSUE2);
  assign mul_src1   = src1_q;
  assign mul_src2   = src2_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = result_q;

endmodule

// File: tb/tb_nios2_mult_result_collector.sv
// Bench for nios2_mult_result_collector: directed corner cases plus random
// operands, checked against plain 64-bit arithmetic and a cycle schedule
// derived from the cell latency. A small cell model supplies partial products.
module tb_nios2_mult_result_collector;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_src1, cmd_src2;
  logic        cmd_hi;
  logic [31:0] mul_src1, mul_src2;
  logic        mul_en;
  logic [31:0] mul_p1, mul_p2, mul_p3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  int total = 0;
  int bad   = 0;

  nios2_mult_result_collector #(.CELL_LATENCY(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src1  (cmd_src1),
    .cmd_src2  (cmd_src2),
`ifdef MULT_HI_WORD_EN
    .cmd_hi    (cmd_hi),
`endif
    .mul_src1  (mul_src1),
    .mul_src2  (mul_src2),
    .mul_en    (mul_en),
    .mul_p1    (mul_p1),
    .mul_p2    (mul_p2),
    .mul_p3    (mul_p3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  // Cell model: L enable-gated stages carrying {p1,p2,p3}.
  logic [95:0] pipe [L];
  always @(posedge clk) begin
    if (mul_en) begin
      pipe[0] <= {32'(mul_src1[15:0]) * 32'(mul_src2[15:0]),
                  32'(mul_src1[15:0]) * 32'(mul_src2[31:16]),
                  32'(mul_src1[31:16]) * 32'(mul_src2[15:0])};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mul_p1 = pipe[L-1][95:64];
  assign mul_p2 = pipe[L-1][63:32];
  assign mul_p3 = pipe[L-1][31:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input bit hi);
    logic [63:0] full;
    full = {32'b0, a} * {32'b0, b};
    return hi ? full[63:32] : full[31:0];
  endfunction

  // One full transaction with schedule checks and bp cycles of back-pressure.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hi,
                       input int bp, input string tag);
    logic [31:0] exp;
    int waited, resp_at;
    bit men_exp;
    exp = model(a, b, hi);
    resp_at = hi ? 2*L + 3 : L + 2;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!cmd_ready) begin
      check({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_src1  = a;
    cmd_src2  = b;
    cmd_hi    = hi;
    tick();
    // Busy-time junk on the command side must be ignored.
    cmd_valid = 1'($urandom);
    cmd_src1  = $urandom;
    cmd_src2  = $urandom;
    cmd_hi    = 1'($urandom);
    for (int i = 1; i <= resp_at; i++) begin
      if (i > 1) tick();
      men_exp = (i <= L) || (hi && i >= L + 2 && i <= 2*L + 1);
      check({tag, "_mul_en"}, 64'(mul_en), 64'(men_exp));
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(i == resp_at));
      check({tag, "_cmd_ready_busy"}, 64'(cmd_ready), 0);
    end
    check({tag, "_result"}, 64'(rsp_result), 64'(exp));
    for (int j = 0; j < bp; j++) begin
      tick();
      check({tag, "_bp_valid"}, 64'(rsp_valid), 1);
      check({tag, "_bp_result"}, 64'(rsp_result), 64'(exp));
      check({tag, "_bp_cmd_ready"}, 64'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check({tag, "_post_valid"}, 64'(rsp_valid), 0);
    check({tag, "_post_cmd_ready"}, 64'(cmd_ready), 1);
  endtask

  task automatic reset_abort();
    cmd_valid = 1'b1;
    cmd_src1  = 32'd1234;
    cmd_src2  = 32'd5678;
    cmd_hi    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("abort_in_issue", 64'(mul_en), 1);
    reset = 1'b1;
    #1;
    check("abort_ready_in_reset", 64'(cmd_ready), 0);
    @(posedge clk);
    #1;
    check("abort_mul_en", 64'(mul_en), 0);
    check("abort_valid", 64'(rsp_valid), 0);
    reset = 1'b0;
    #1;
    check("abort_ready_after", 64'(cmd_ready), 1);
    for (int i = 0; i < L + 4; i++) begin
      tick();
      check("abort_no_rsp", 64'(rsp_valid), 0);
    end
  endtask

  task automatic back_to_back();
    logic [31:0] av [2];
    logic [31:0] bv [2];
    int acc_cyc [2];
    int n_acc, n_rsp, c;
    bit accepted;
    av[0] = $urandom; bv[0] = $urandom;
    av[1] = $urandom; bv[1] = $urandom;
    n_acc = 0; n_rsp = 0; c = 0; accepted = 0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_src1  = av[0];
    cmd_src2  = bv[0];
    cmd_hi    = 1'b0;
    #1;
    while (n_rsp < 2 && c < 60) begin
      if (accepted) begin
        accepted = 0;
        if (n_acc < 2) begin
          cmd_src1 = av[n_acc];
          cmd_src2 = bv[n_acc];
        end else begin
          cmd_valid = 1'b0;
        end
        #1;
      end
      if (rsp_valid) begin
        check("b2b_result", 64'(rsp_result), 64'(model(av[n_rsp], bv[n_rsp], 1'b0)));
        n_rsp++;
      end
      if (cmd_valid && cmd_ready && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        accepted = 1;
      end
      tick();
      c++;
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("b2b_rsp_count", 64'(n_rsp), 2);
    if (n_acc == 2) check("b2b_interval", 64'(acc_cyc[1] - acc_cyc[0]), 64'(L + 3));
    else            check("b2b_acc_count", 64'(n_acc), 2);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_src1  = '0;
    cmd_src2  = '0;
    cmd_hi    = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", 64'(cmd_ready), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_mul_en", 64'(mul_en), 0);
    check("rst_rsp_result", 64'(rsp_result), 0);
    check("rst_mul_src1", 64'(mul_src1), 0);
    check("rst_mul_src2", 64'(mul_src2), 0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", 64'(cmd_ready), 1);

    do_op(32'd7, 32'd6, 1'b0, 0, "seven_six");
    check("seven_six_value", 64'(model(32'd7, 32'd6, 1'b0)), 64'h2A);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, "all_ones_lo");
    do_op(32'h0001_0000, 32'h0001_0000, 1'b0, 0, "pow16_lo");
    do_op(32'h0000_1234, 32'h0000_0010, 1'b0, 5, "backpressure");
`ifdef MULT_HI_WORD_EN
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "all_ones_hi");
    do_op(32'h0001_0000, 32'h0001_0000, 1'b1, 2, "pow16_hi");
`endif
    reset_abort();
    back_to_back();
    for (int n = 0; n < 25; n++) begin
      logic [31:0] a, b;
      bit hi;
      a = $urandom;
      b = $urandom;
      if (n % 5 == 0) a = {16'h0, a[15:0]};
      if (n % 7 == 0) b = 32'hFFFF_FFFF;
`ifdef MULT_HI_WORD_EN
      hi = 1'($urandom);
`else
      hi = 1'b0;
`endif
      do_op(a, b, hi, int'($urandom_range(0, 3)), "random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
